jk_excitation_counter: RTL and testbench



---
 rtl/jk_excitation_counter_pkg.sv | 14 +
 rtl/jk_excitation_counter_jk_excite_bit.sv | 27 ++
 rtl/jk_excitation_counter.sv | 114 +++++++++++
 tb/tb_jk_excitation_counter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/jk_excitation_counter_pkg.sv
// Shared definitions for the JK-excitation counter: FSM state encoding and
// count-direction constants.
package jk_excitation_counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/jk_excitation_counter_jk_excite_bit.sv
// One counter bit: inverse JK excitation from (q, desired n) to (j, k), and a
// JK flip-flop that updates literally by its characteristic equation.
module jk_excite_bit (
  input  logic clock,
  input  logic reset,
  input  logic i_n,
  output logic o_q,
  output logic o_j,
  output logic o_k
);

  logic r_q;

  // Only set on 0->1 and reset on 1->0, so J and K are never both high.
  assign o_j = i_n & ~r_q;
  assign o_k = ~i_n & r_q;
  assign o_q = r_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_q <= 1'b0;
    end else begin
      r_q <= (o_j & ~r_q) | (~o_k & r_q);
    end
  end

endmodule

// File: rtl/jk_excitation_counter.sv
// Programmable modulo up/down counter built from JK bits; picks the next count
// each cycle and exports the J/K drive that produces it.
module jk_excitation_counter
  import jk_excitation_counter_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int RESET_LIMIT = 9
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic [WIDTH-1:0] limit,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LIMIT_INIT = WIDTH'(RESET_LIMIT);
  localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);

  state_t           r_state;
  logic             r_dir;
  logic [WIDTH-1:0] r_limit;
  logic             r_wrap;

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_next;
  logic             w_wrap_edge;

  always_comb begin
    w_next      = w_q;
    w_wrap_edge = 1'b0;
    case (r_state)
      IDLE: begin
        if (load_en) begin
          w_next = load_value;
        end
      end
      RUN: begin
        if (!stop) begin
          if (r_dir == DIR_UP) begin
            if (w_q >= r_limit) begin
              w_next      = '0;
              w_wrap_edge = 1'b1;
            end else begin
              w_next = w_q + ONE;
            end
          end else if (w_q == '0) begin
            w_next      = r_limit;
            w_wrap_edge = 1'b1;
          end else if (w_q > r_limit) begin
            // Out-of-range start value snaps back to the terminal count.
            w_next = r_limit;
          end else begin
            w_next = w_q - ONE;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_dir   <= DIR_UP;
      r_limit <= LIMIT_INIT;
      r_wrap  <= 1'b0;
    end else begin
      r_wrap <= w_wrap_edge;
      case (r_state)
        IDLE: begin
          if (!load_en && start) begin
            r_state <= RUN;
            r_dir   <= dir;
            r_limit <= limit;
          end
        end
        RUN: begin
          if (stop) begin
            r_state <= IDLE;
          end else if (w_wrap_edge) begin
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    jk_excite_bit u_bit (
      .clock (clock),
      .reset (reset),
      .i_n   (w_next[gi]),
      .o_q   (w_q[gi]),
      .o_j   (j_out[gi]),
      .o_k   (k_out[gi])
    );
  end

  assign count = w_q;
  assign busy  = (r_state == RUN);
  assign done  = (r_state == DONE);
  assign wrap  = r_wrap;

endmodule

// File: tb/tb_jk_excitation_counter.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized stimulus compared every cycle against a behavioural model.
module tb_jk_excitation_counter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       dir = 1'b1;
  logic [3:0] limit = 4'd0;
  logic       load_en = 1'b0;
  logic [3:0] load_value = 4'd0;
  logic [3:0] count, j_out, k_out;
  logic       busy, done, wrap;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  jk_excitation_counter #(.WIDTH(4), .RESET_LIMIT(9)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .dir        (dir),
    .limit      (limit),
    .load_en    (load_en),
    .load_value (load_value),
    .count      (count),
    .j_out      (j_out),
    .k_out      (k_out),
    .busy       (busy),
    .done       (done),
    .wrap       (wrap)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0=idle, 1=run, 2=done; plain integer arithmetic.
  int m_mode  = 0;
  int m_count = 0;
  int m_up    = 1;
  int m_limit = 9;
  int m_wrap  = 0;

  function automatic int model_next();
    int c = m_count;
    int l = m_limit;
    if (m_mode == 1 && !stop) begin
      if (m_up != 0) return (c < l) ? c + 1 : 0;
      if (c == 0) return l;
      return (c > l) ? l : c - 1;
    end
    if (m_mode == 0 && load_en) return int'(load_value);
    return c;
  endfunction

  function automatic int model_wraps();
    if (m_mode != 1 || stop) return 0;
    if (m_up != 0) return (m_count >= m_limit) ? 1 : 0;
    return (m_count == 0) ? 1 : 0;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_mode <= 0; m_count <= 0; m_up <= 1; m_limit <= 9; m_wrap <= 0;
    end else begin
      m_wrap  <= model_wraps();
      m_count <= model_next();
      if (m_mode == 0) begin
        if (!load_en && start) begin
          m_mode <= 1; m_up <= int'(dir); m_limit <= int'(limit);
        end
      end else if (m_mode == 1) begin
        if (stop) m_mode <= 0;
        else if (model_wraps() != 0) m_mode <= 2;
      end else begin
        m_mode <= 0;
      end
    end
  end

  // Gate-level JK reference driven only by the exported J/K vectors.
  logic [3:0] g_q = 4'd0;
  always @(posedge clock or posedge reset) begin
    if (reset) g_q <= 4'd0;
    else       g_q <= (j_out & ~g_q) | (~k_out & g_q);
  end

  bit cmp_en = 1'b0;
  always @(negedge clock) begin
    if (cmp_en) begin
      int nx;
      nx = model_next();
      check("count", int'(count), m_count);
      check("busy", int'(busy), (m_mode == 1) ? 1 : 0);
      check("done", int'(done), (m_mode == 2) ? 1 : 0);
      check("wrap", int'(wrap), m_wrap);
      check("j_out", int'(j_out), nx & ~m_count & 15);
      check("k_out", int'(k_out), ~nx & m_count & 15);
      check("jk_both_high", int'(j_out & k_out), 0);
      check("gate_jk_track", int'(g_q), int'(count));
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic go(input logic d, input logic [3:0] lim);
    start = 1'b1; dir = d; limit = lim;
    tick();
    start = 1'b0;
  endtask

  task automatic do_load(input logic [3:0] v);
    load_en = 1'b1; load_value = v;
    tick();
    load_en = 1'b0;
  endtask

  initial begin
    #1 cmp_en = 1'b1;
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    check("rst_count", int'(count), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_jk", int'({j_out, k_out}), 0);

    // Full up pass, limit 9.
    go(1'b1, 4'd9);
    for (int i = 0; i <= 9; i++) begin
      check("up_count", int'(count), i);
      check("up_busy", int'(busy), 1);
      tick();
    end
    check("up_done", int'({done, wrap}), 3);
    check("up_wrap_count", int'(count), 0);
    tick();
    check("up_idle", int'({busy, done, wrap}), 0);

    // Load 3, count down with limit 5.
    do_load(4'd3);
    go(1'b0, 4'd5);
    for (int i = 3; i >= 0; i--) begin
      check("dn_count", int'(count), i);
      tick();
    end
    check("dn_wrap_count", int'(count), 5);
    check("dn_done", int'({done, wrap}), 3);
    tick();

    // Excitation for 7 -> 8.
    do_load(4'd7);
    go(1'b1, 4'd15);
    check("exc_j", int'(j_out), 8);
    check("exc_k", int'(k_out), 7);
    tick();
    check("exc_count", int'(count), 8);
    stop = 1'b1;
    #1 check("stop_jk_hold", int'({j_out, k_out}), 0);
    tick();
    stop = 1'b0;
    check("stop_idle", int'({busy, count}), 8);

    // Stop on the 4th RUN cycle.
    do_load(4'd0);
    go(1'b1, 4'd9);
    repeat (3) tick();
    check("stop4_count", int'(count), 3);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop4_freeze", int'(count), 3);
    check("stop4_flags", int'({busy, done, wrap}), 0);

    // Async reset mid-RUN at count 6.
    do_load(4'd0);
    go(1'b1, 4'd9);
    repeat (6) tick();
    check("pre_rst_count", int'(count), 6);
    #1 reset = 1'b1;
    #1 check("arst_count", int'(count), 0);
    check("arst_busy", int'(busy), 0);
    reset = 1'b0;
    tick();
    check("arst_no_done", int'({done, wrap}), 0);

    // limit = 0 in both directions.
    for (int d = 0; d < 2; d++) begin
      go(d[0], 4'd0);
      check("lim0_run", int'({busy, count}), 16);
      tick();
      check("lim0_done", int'({done, wrap, count}), 48);
      tick();
    end

    // load and start together: load wins.
    load_en = 1'b1; load_value = 4'd5; start = 1'b1;
    tick();
    load_en = 1'b0; start = 1'b0;
    check("load_wins", int'({busy, count}), 5);

    // Randomized phase.
    for (int n = 0; n < 3000; n++) begin
      start      = ($urandom % 4) == 0;
      stop       = ($urandom % 16) == 0;
      dir        = 1'($urandom);
      limit      = 4'($urandom);
      load_en    = ($urandom % 8) == 0;
      load_value = 4'($urandom);
      if (($urandom % 400) == 0) begin
        #1 reset = 1'b1;
        #1 reset = 1'b0;
      end
      tick();
    end

    @(negedge clock);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
